// File: rtl/block_encrypt.sv
// block_encrypt: iterative CSA block-cipher encryption (56 rounds, the
// inverse of block_decrypt). A 64-bit plaintext and the 448-bit expanded key
// are captured on accept. One round is applied per RUN cycle, using key byte
// kk[round] in ascending order 0..55. The ciphertext is held in DONE until it
// is handshaken.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   plaintext handshake (in_ready high only in IDLE)
//   in_data[63:0]       plaintext, byte 0 = in_data[63:56]
//   kk[447:0]           key schedule, byte i = kk[447-8i -: 8]
//   out_valid/out_ready ciphertext handshake (out_valid high only in DONE)
//   out_data[63:0]      ciphertext, reads 0 while out_valid = 0
//   busy                high in RUN and DONE
//
// Build option: define BLOCK_ENCRYPT_DUAL_ROUND_EN to chain two rounds per
// cycle (latency 28). The ciphertext is the same in both builds.

// CSA block-cipher S-box. This is the same table block_decrypt uses.
module block_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  localparam logic [7:0] SBOX [256] = '{
    8'h3a, 8'hea, 8'h68, 8'hfe, 8'h33, 8'he9, 8'h88, 8'h1a, 8'h83, 8'hcf, 8'he1, 8'h7f, 8'hba, 8'he2, 8'h38, 8'h12,
    8'he8, 8'h27, 8'h61, 8'h95, 8'h0c, 8'h36, 8'he5, 8'h70, 8'ha2, 8'h06, 8'h82, 8'h7c, 8'h17, 8'ha3, 8'h26, 8'h49,
    8'hbe, 8'h7a, 8'h6d, 8'h47, 8'hc1, 8'h51, 8'h8f, 8'hf3, 8'hcc, 8'h5b, 8'h67, 8'hbd, 8'hcd, 8'h18, 8'h08, 8'hc9,
    8'hff, 8'h69, 8'hef, 8'h03, 8'h4e, 8'h48, 8'h4a, 8'h84, 8'h3f, 8'hb4, 8'h10, 8'h04, 8'hdc, 8'hf5, 8'h5c, 8'hc6,
    8'h16, 8'hab, 8'hac, 8'h4c, 8'hf1, 8'h6a, 8'h2f, 8'h3c, 8'h3b, 8'hd4, 8'hd5, 8'h94, 8'hd0, 8'hc4, 8'h63, 8'h62,
    8'h71, 8'ha1, 8'hf9, 8'h4f, 8'h2e, 8'haa, 8'hc5, 8'h56, 8'he3, 8'h39, 8'h93, 8'hce, 8'h65, 8'h64, 8'he4, 8'h58,
    8'h6c, 8'h19, 8'h42, 8'h79, 8'hdd, 8'hee, 8'h96, 8'hf6, 8'h8a, 8'hec, 8'h1e, 8'h85, 8'h53, 8'h45, 8'hde, 8'hbb,
    8'h7e, 8'h0a, 8'h9a, 8'h13, 8'h2a, 8'h9d, 8'hc2, 8'h5e, 8'h5a, 8'h1f, 8'h32, 8'h35, 8'h9c, 8'ha8, 8'h73, 8'h30,
    8'h29, 8'h3d, 8'he7, 8'h92, 8'h87, 8'h1b, 8'h2b, 8'h4b, 8'ha5, 8'h57, 8'h97, 8'h40, 8'h15, 8'he6, 8'hbc, 8'h0e,
    8'heb, 8'hc3, 8'h34, 8'h2d, 8'hb8, 8'h44, 8'h25, 8'ha4, 8'h1c, 8'hc7, 8'h23, 8'hed, 8'h90, 8'h6e, 8'h50, 8'h00,
    8'h99, 8'h9e, 8'h4d, 8'hd9, 8'hda, 8'h8d, 8'h6f, 8'h5f, 8'h3e, 8'hd7, 8'h21, 8'h74, 8'h86, 8'hdf, 8'h6b, 8'h05,
    8'h8e, 8'h5d, 8'h37, 8'h11, 8'hd2, 8'h28, 8'h75, 8'hd6, 8'ha7, 8'h77, 8'h24, 8'hbf, 8'hf0, 8'hb0, 8'h02, 8'hb7,
    8'hf8, 8'hfc, 8'h81, 8'h09, 8'hb1, 8'h01, 8'h76, 8'h91, 8'h7d, 8'h0f, 8'hc8, 8'ha0, 8'hf2, 8'hcb, 8'h78, 8'h60,
    8'hd1, 8'hf7, 8'he0, 8'hb5, 8'h98, 8'h22, 8'hb3, 8'h20, 8'h1d, 8'ha6, 8'hdb, 8'h7b, 8'h59, 8'h9f, 8'hae, 8'h31,
    8'hfb, 8'hd3, 8'hb6, 8'hca, 8'h43, 8'h72, 8'h07, 8'hf4, 8'hd8, 8'h41, 8'h14, 8'h55, 8'h0d, 8'h54, 8'h8b, 8'hb9,
    8'had, 8'h46, 8'h0b, 8'haf, 8'h80, 8'h52, 8'h2c, 8'hfa, 8'h8c, 8'h89, 8'h66, 8'hfd, 8'hb2, 8'ha9, 8'h9b, 8'hc0
  };
  assign o_out = SBOX[i_in];
endmodule

// One encryption round. The byte W[j] is i_blk[63-8j -: 8].
//   S = sbox(key ^ W6), L = W7 ^ S
//   W' = {L, W0, W1^L, W2^L, W3^L, W4, W5^perm(S), W6}
module block_encrypt_round (
  input  logic [63:0] i_blk,
  input  logic [7:0]  i_key,
  output logic [63:0] o_blk
);
  logic [7:0] w_idx, w_s, w_l, w_p;

  assign w_idx = i_key ^ i_blk[15:8];
  block_sbox u_sbox (.i_in(w_idx), .o_out(w_s));

  assign w_l = i_blk[7:0] ^ w_s;
  // Block bit permutation: s0->p1, s1->p7, s2->p5, s3->p4, s4->p2, s5->p6, s6->p0, s7->p3
  assign w_p = {w_s[1], w_s[5], w_s[2], w_s[3], w_s[7], w_s[4], w_s[0], w_s[6]};

  assign o_blk = {w_l, i_blk[63:56], i_blk[55:48] ^ w_l, i_blk[47:40] ^ w_l,
                  i_blk[39:32] ^ w_l, i_blk[31:24], i_blk[23:16] ^ w_p, i_blk[15:8]};
endmodule

module block_encrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic [447:0] kk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_st, w_next;
  logic [63:0]      r_blk;
  logic [55:0][7:0] r_key;   // byte i of the schedule sits at r_key[55-i]
  logic [5:0]       r_cnt;
  logic [63:0]      w_rnd;

`ifdef BLOCK_ENCRYPT_DUAL_ROUND_EN
  localparam logic [5:0] STEP = 6'd2;
  localparam logic [5:0] LAST = 6'd54;   // pair (54,55) is the final step
  logic [63:0] w_mid;
  logic [5:0]  w_k0, w_k1;
  assign w_k0 = 6'd55 - r_cnt;
  assign w_k1 = 6'd54 - r_cnt;
  block_encrypt_round u_rnd0 (.i_blk(r_blk), .i_key(r_key[w_k0]), .o_blk(w_mid));
  block_encrypt_round u_rnd1 (.i_blk(w_mid), .i_key(r_key[w_k1]), .o_blk(w_rnd));
`else
  localparam logic [5:0] STEP = 6'd1;
  localparam logic [5:0] LAST = 6'd55;
  logic [5:0] w_k0;
  assign w_k0 = 6'd55 - r_cnt;
  block_encrypt_round u_rnd0 (.i_blk(r_blk), .i_key(r_key[w_k0]), .o_blk(w_rnd));
`endif

  always_ff @(posedge clk) begin
    if (rst) r_st <= IDLE;
    else     r_st <= w_next;
  end

  always_comb begin
    w_next = r_st;
    unique case (r_st)
      IDLE:    if (in_valid)       w_next = RUN;
      RUN:     if (r_cnt == LAST)  w_next = DONE;
      DONE:    if (out_ready)      w_next = IDLE;
      default:                     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk <= '0;
      r_key <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_st)
        IDLE: if (in_valid) begin
          r_blk <= in_data;
          r_key <= kk;
          r_cnt <= '0;
        end
        RUN: begin
          r_blk <= w_rnd;
          // The counter parks on the last round so it never wraps into an extra one.
          if (r_cnt != LAST) r_cnt <= r_cnt + STEP;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_st == IDLE);
  assign out_valid = (r_st == DONE);
  assign busy      = (r_st != IDLE);
  assign out_data  = out_valid ? r_blk : 64'h0;
endmodule

// File: tb/tb_block_encrypt.sv
module tb_block_encrypt;
`ifdef BLOCK_ENCRYPT_DUAL_ROUND_EN
  localparam int LAT = 28;
`else
  localparam int LAT = 56;
`endif
  localparam int NRAND = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic [447:0] kk = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  block_encrypt dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .kk(kk), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] SB [256] = '{
    8'h3a, 8'hea, 8'h68, 8'hfe, 8'h33, 8'he9, 8'h88, 8'h1a, 8'h83, 8'hcf, 8'he1, 8'h7f, 8'hba, 8'he2, 8'h38, 8'h12,
    8'he8, 8'h27, 8'h61, 8'h95, 8'h0c, 8'h36, 8'he5, 8'h70, 8'ha2, 8'h06, 8'h82, 8'h7c, 8'h17, 8'ha3, 8'h26, 8'h49,
    8'hbe, 8'h7a, 8'h6d, 8'h47, 8'hc1, 8'h51, 8'h8f, 8'hf3, 8'hcc, 8'h5b, 8'h67, 8'hbd, 8'hcd, 8'h18, 8'h08, 8'hc9,
    8'hff, 8'h69, 8'hef, 8'h03, 8'h4e, 8'h48, 8'h4a, 8'h84, 8'h3f, 8'hb4, 8'h10, 8'h04, 8'hdc, 8'hf5, 8'h5c, 8'hc6,
    8'h16, 8'hab, 8'hac, 8'h4c, 8'hf1, 8'h6a, 8'h2f, 8'h3c, 8'h3b, 8'hd4, 8'hd5, 8'h94, 8'hd0, 8'hc4, 8'h63, 8'h62,
    8'h71, 8'ha1, 8'hf9, 8'h4f, 8'h2e, 8'haa, 8'hc5, 8'h56, 8'he3, 8'h39, 8'h93, 8'hce, 8'h65, 8'h64, 8'he4, 8'h58,
    8'h6c, 8'h19, 8'h42, 8'h79, 8'hdd, 8'hee, 8'h96, 8'hf6, 8'h8a, 8'hec, 8'h1e, 8'h85, 8'h53, 8'h45, 8'hde, 8'hbb,
    8'h7e, 8'h0a, 8'h9a, 8'h13, 8'h2a, 8'h9d, 8'hc2, 8'h5e, 8'h5a, 8'h1f, 8'h32, 8'h35, 8'h9c, 8'ha8, 8'h73, 8'h30,
    8'h29, 8'h3d, 8'he7, 8'h92, 8'h87, 8'h1b, 8'h2b, 8'h4b, 8'ha5, 8'h57, 8'h97, 8'h40, 8'h15, 8'he6, 8'hbc, 8'h0e,
    8'heb, 8'hc3, 8'h34, 8'h2d, 8'hb8, 8'h44, 8'h25, 8'ha4, 8'h1c, 8'hc7, 8'h23, 8'hed, 8'h90, 8'h6e, 8'h50, 8'h00,
    8'h99, 8'h9e, 8'h4d, 8'hd9, 8'hda, 8'h8d, 8'h6f, 8'h5f, 8'h3e, 8'hd7, 8'h21, 8'h74, 8'h86, 8'hdf, 8'h6b, 8'h05,
    8'h8e, 8'h5d, 8'h37, 8'h11, 8'hd2, 8'h28, 8'h75, 8'hd6, 8'ha7, 8'h77, 8'h24, 8'hbf, 8'hf0, 8'hb0, 8'h02, 8'hb7,
    8'hf8, 8'hfc, 8'h81, 8'h09, 8'hb1, 8'h01, 8'h76, 8'h91, 8'h7d, 8'h0f, 8'hc8, 8'ha0, 8'hf2, 8'hcb, 8'h78, 8'h60,
    8'hd1, 8'hf7, 8'he0, 8'hb5, 8'h98, 8'h22, 8'hb3, 8'h20, 8'h1d, 8'ha6, 8'hdb, 8'h7b, 8'h59, 8'h9f, 8'hae, 8'h31,
    8'hfb, 8'hd3, 8'hb6, 8'hca, 8'h43, 8'h72, 8'h07, 8'hf4, 8'hd8, 8'h41, 8'h14, 8'h55, 8'h0d, 8'h54, 8'h8b, 8'hb9,
    8'had, 8'h46, 8'h0b, 8'haf, 8'h80, 8'h52, 8'h2c, 8'hfa, 8'h8c, 8'h89, 8'h66, 8'hfd, 8'hb2, 8'ha9, 8'h9b, 8'hc0
  };

  function automatic logic [7:0] perm(input logic [7:0] s);
    logic [7:0] p;
    p[1] = s[0]; p[7] = s[1]; p[5] = s[2]; p[4] = s[3];
    p[2] = s[4]; p[6] = s[5]; p[0] = s[6]; p[3] = s[7];
    return p;
  endfunction

  // Byte-array reference encryption, rounds 0..55.
  function automatic logic [63:0] enc_model(input logic [63:0] pt, input logic [447:0] k);
    logic [7:0] w [8];
    logic [7:0] s, l;
    logic [63:0] r;
    for (int j = 0; j < 8; j++) w[j] = pt[63-8*j -: 8];
    for (int i = 0; i < 56; i++) begin
      s = SB[k[447-8*i -: 8] ^ w[6]];
      l = w[7] ^ s;
      w[7] = w[6]; w[6] = w[5] ^ perm(s); w[5] = w[4]; w[4] = w[3] ^ l;
      w[3] = w[2] ^ l; w[2] = w[1] ^ l; w[1] = w[0]; w[0] = l;
    end
    for (int j = 0; j < 8; j++) r[63-8*j -: 8] = w[j];
    return r;
  endfunction

  // Reference decryption, rounds 55..0, used for the round-trip check.
  function automatic logic [63:0] dec_model(input logic [63:0] ct, input logic [447:0] k);
    logic [7:0] w [8];
    logic [7:0] s, l;
    logic [63:0] r;
    for (int j = 0; j < 8; j++) w[j] = ct[63-8*j -: 8];
    for (int i = 55; i >= 0; i--) begin
      s = SB[k[447-8*i -: 8] ^ w[7]];
      l = w[0];
      w[0] = w[1]; w[1] = w[2] ^ l; w[2] = w[3] ^ l; w[3] = w[4] ^ l;
      w[4] = w[5]; w[5] = w[6] ^ perm(s); w[6] = w[7]; w[7] = l ^ s;
    end
    for (int j = 0; j < 8; j++) r[63-8*j -: 8] = w[j];
    return r;
  endfunction

  function automatic logic [447:0] rand_key();
    logic [447:0] k;
    for (int i = 0; i < 14; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Present a block and push its expected ciphertext; returns just after the accept edge.
  task automatic start_block(input logic [63:0] pt, input logic [447:0] k);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; in_data = pt; kk = k;
    sb_q.push_back(enc_model(pt, k));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid; optionally churn inputs (and a stray in_valid) meanwhile.
  task automatic wait_out(input bit scramble, output int n);
    n = 0;
    while (!out_valid && n < LAT + 40) begin
      if (scramble) begin
        in_data = {$urandom, $urandom}; kk = rand_key(); in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic pop_exp(output logic [63:0] e);
    if (sb_q.size() == 0) e = 'x;
    else e = sb_q.pop_front();
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_zero();
    int n; logic [63:0] e;
    start_block(64'h0, 448'h0);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL zero_run_flags busy %b in_ready %b want 1 0", busy, in_ready); end
    wait_out(1'b0, n);
    pop_exp(e);
    checks++; if (n !== LAT) begin errors++; $display("FAIL zero_latency got %0d want %0d", n, LAT); end
    checks++; if (out_data !== e) begin errors++; $display("FAIL zero_data got %h want %h", out_data, e); end
    handshake();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0) begin
      errors++; $display("FAIL zero_release in_ready %b out_valid %b out_data %h want 1 0 0", in_ready, out_valid, out_data); end
  endtask

  task automatic test_vector();
    int n; logic [63:0] e; logic [447:0] k;
    for (int i = 0; i < 56; i++) k[447-8*i -: 8] = 8'(i);
    start_block(64'h0123456789ABCDEF, k);
    wait_out(1'b1, n);
    pop_exp(e);
    checks++; if (n !== LAT) begin errors++; $display("FAIL vector_latency got %0d want %0d", n, LAT); end
    checks++; if (out_data !== e) begin errors++; $display("FAIL vector_data got %h want %h", out_data, e); end
    checks++; if (dec_model(out_data, k) !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL vector_roundtrip got %h want 0123456789abcdef", dec_model(out_data, k)); end
    handshake();
  endtask

  task automatic test_random();
    int n; logic [63:0] e, pt; logic [447:0] k;
    for (int t = 0; t < NRAND; t++) begin
      pt = {$urandom, $urandom}; k = rand_key();
      start_block(pt, k);
      wait_out(1'b1, n);
      pop_exp(e);
      checks++; if (n !== LAT) begin errors++; $display("FAIL rand_latency #%0d got %0d want %0d", t, n, LAT); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL rand_data #%0d got %h want %h", t, out_data, e); end
      checks++; if (dec_model(out_data, k) !== pt) begin
        errors++; $display("FAIL rand_roundtrip #%0d got %h want %h", t, dec_model(out_data, k), pt); end
      handshake();
    end
  endtask

  task automatic test_hold();
    int n; logic [63:0] e, held; logic [447:0] k;
    k = rand_key();
    start_block(64'hDEADBEEF_CAFEF00D, k);
    wait_out(1'b0, n);
    pop_exp(e);
    held = out_data;
    checks++; if (held !== e) begin errors++; $display("FAIL hold_data got %h want %h", held, e); end
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; kk = rand_key();
      @(posedge clk); #1;
      checks++; if (out_data !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d data %h valid %b in_ready %b want %h 1 0", c, out_data, out_valid, in_ready, e); end
    end
    in_valid = 1'b0;
    handshake();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release in_ready %b out_valid %b busy %b want 1 0 0", in_ready, out_valid, busy); end
  endtask

  task automatic test_abort();
    int n; logic [63:0] e, pt; logic [447:0] k;
    logic [63:0] dropped;
    start_block({$urandom, $urandom}, rand_key());
    dropped = sb_q.pop_back();   // this block is aborted and never produces output
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_state in_ready %b out_valid %b out_data %h busy %b want 1 0 0 0", in_ready, out_valid, out_data, busy); end
    n = 0;
    repeat (LAT + 5) begin @(posedge clk); #1; if (out_valid) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL abort_no_output got %0d valid cycles want 0 (dropped %h)", n, dropped); end
    // New block with out_ready held high through RUN: only the DONE cycle may complete it.
    pt = {$urandom, $urandom}; k = rand_key();
    start_block(pt, k);
    out_ready = 1'b1;
    wait_out(1'b0, n);
    pop_exp(e);
    checks++; if (n !== LAT) begin errors++; $display("FAIL abort_new_latency got %0d want %0d", n, LAT); end
    checks++; if (out_data !== e) begin errors++; $display("FAIL abort_new_data got %h want %h", out_data, e); end
    @(posedge clk); #1 out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_new_release in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero();
    test_vector();
    test_hold();
    test_abort();
    test_random();
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
